// File: rtl/hamming_stream_ctrl.sv
// Hamming(7,4) single-error corrector with valid/ready stream handshake
// and per-frame / running correction statistics.
module hamming_stream_ctrl #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_fixed,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] total_fixed,
    input  logic             clr_stats
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam int unsigned     WC_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);

    logic [1:0]       state;
    logic [7:1]       hold;
    logic [WC_W-1:0]  word_cnt;
    logic [CNT_W-1:0] acc;
    logic [2:0]       syn;
    logic [7:1]       corr;
    logic             out_hs;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] total_inc;

    // Bit 0 of the codeword carries no information.
    logic unused_bit0;
    assign unused_bit0 = in_code[0];

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign out_hs    = out_valid & out_ready;

    assign acc_inc   = (acc == '1) ? acc : acc + 1'b1;
    assign total_inc = (total_fixed == '1) ? total_fixed : total_fixed + 1'b1;

    always_comb begin
        syn[0] = hold[1] ^ hold[3] ^ hold[5] ^ hold[7];
        syn[1] = hold[2] ^ hold[3] ^ hold[6] ^ hold[7];
        syn[2] = hold[4] ^ hold[5] ^ hold[6] ^ hold[7];
        corr   = hold;
        for (int unsigned i = 1; i <= 7; i++) begin
            corr[i] = hold[i] ^ (syn == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            hold          <= '0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_fixed     <= 1'b0;
            frame_done    <= 1'b0;
            frame_err_cnt <= '0;
            total_fixed   <= '0;
            word_cnt      <= '0;
            acc           <= '0;
        end else begin
            frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        hold  <= in_code[7:1];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    out_data     <= {corr[7], corr[6], corr[5], corr[3]};
                    out_syndrome <= syn;
                    out_fixed    <= |syn;
                    state        <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Last word of a frame folds its own error into the published count.
            if (out_hs) begin
                if (word_cnt == WC_LAST) begin
                    word_cnt      <= '0;
                    frame_err_cnt <= out_fixed ? acc_inc : acc;
                    acc           <= '0;
                    frame_done    <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    if (out_fixed) acc <= acc_inc;
                end
            end

            if (clr_stats)
                total_fixed <= '0;
            else if (out_hs && out_fixed)
                total_fixed <= total_inc;
        end
    end

endmodule

// File: tb/tb_hamming_stream_ctrl.sv
// Directed bench for hamming_stream_ctrl: a wide-counter and a 2-bit-counter
// instance share one stimulus stream.
module tb_hamming_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr_stats;
    logic [7:0]  in_code;
    logic        in_ready, out_valid, out_fixed, frame_done;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [15:0] frame_err_cnt, total_fixed;
    logic        s_in_ready, s_out_valid, s_out_fixed, s_frame_done;
    logic [3:0]  s_out_data;
    logic [2:0]  s_out_syndrome;
    logic [1:0]  s_frame_err_cnt, s_total_fixed;

    always #5 clk = ~clk;

    hamming_stream_ctrl #(.FRAME_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_fixed(out_fixed), .frame_done(frame_done),
        .frame_err_cnt(frame_err_cnt), .total_fixed(total_fixed), .clr_stats(clr_stats)
    );

    hamming_stream_ctrl #(.FRAME_LEN(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_syndrome(s_out_syndrome), .out_fixed(s_out_fixed), .frame_done(s_frame_done),
        .frame_err_cnt(s_frame_err_cnt), .total_fixed(s_total_fixed), .clr_stats(clr_stats)
    );

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic       fixed;
    } vec_t;

    vec_t vecs[21];
    int n_pass  = 0;
    int n_total = 0;
    int tot16 = 0, tot2 = 0, acc = 0, wcnt = 0, fe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_word(input logic [7:0] code, input logic [3:0] d, input logic [2:0] s,
                           input logic f, input int stall, input logic clr);
        bit fd;
        in_valid = 1'b1;
        in_code  = code;
        chk("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        in_code  = 8'h55;
        chk("calc_out_valid", 32'(out_valid), 0);
        chk("calc_in_ready", 32'(in_ready), 0);
        @(posedge clk); @(negedge clk);
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(d));
        chk("out_syndrome", 32'(out_syndrome), 32'(s));
        chk("out_fixed", 32'(out_fixed), 32'(f));
        chk("out_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data", 32'(out_data), 32'(d));
            chk("stall_out_syndrome", 32'(out_syndrome), 32'(s));
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_stats = clr;
        @(posedge clk);
        if (clr) begin
            tot16 = 0; tot2 = 0;
        end else if (f) begin
            tot16++;
            if (tot2 < 3) tot2++;
        end
        if (f) acc++;
        fd = 0;
        if (wcnt == 7) begin
            fd = 1; fe = acc; acc = 0; wcnt = 0;
        end else begin
            wcnt++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        clr_stats = 1'b0;
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("s_frame_done", 32'(s_frame_done), 32'(fd));
        chk("total_fixed", 32'(total_fixed), 32'(tot16));
        chk("s_total_fixed", 32'(s_total_fixed), 32'(tot2));
        chk("frame_err_cnt", 32'(frame_err_cnt), 32'(fe));
        chk("s_frame_err_cnt", 32'(s_frame_err_cnt), 32'((fe > 3) ? 3 : fe));
        if (fd) begin
            @(posedge clk); @(negedge clk);
            chk("frame_done_pulse", 32'(frame_done), 0);
            chk("frame_err_hold", 32'(frame_err_cnt), 32'(fe));
        end
    endtask

    initial begin
        vecs[0]  = '{8'h00, 4'h0, 3'd0, 1'b0};
        vecs[1]  = '{8'hDE, 4'hF, 3'd5, 1'b1};
        vecs[2]  = '{8'h01, 4'h0, 3'd0, 1'b0};
        vecs[3]  = '{8'hFF, 4'hF, 3'd0, 1'b0};
        vecs[4]  = '{8'hA4, 4'hA, 3'd0, 1'b0};
        vecs[5]  = '{8'hAC, 4'hA, 3'd3, 1'b1};
        vecs[6]  = '{8'h5A, 4'h5, 3'd0, 1'b0};
        vecs[7]  = '{8'h1A, 4'h5, 3'd6, 1'b1};
        vecs[8]  = '{8'h3C, 4'h3, 3'd0, 1'b0};
        vecs[9]  = '{8'h3D, 4'h3, 3'd0, 1'b0};
        vecs[10] = '{8'hA4, 4'hA, 3'd0, 1'b0};
        vecs[11] = '{8'h5A, 4'h5, 3'd0, 1'b0};
        vecs[12] = '{8'h00, 4'h0, 3'd0, 1'b0};
        vecs[13] = '{8'hFF, 4'hF, 3'd0, 1'b0};
        vecs[14] = '{8'h01, 4'h0, 3'd0, 1'b0};
        vecs[15] = '{8'h3C, 4'h3, 3'd0, 1'b0};
        vecs[16] = '{8'hA6, 4'hA, 3'd1, 1'b1};
        vecs[17] = '{8'h24, 4'hA, 3'd7, 1'b1};
        vecs[18] = '{8'hA0, 4'hA, 3'd2, 1'b1};
        vecs[19] = '{8'hB4, 4'hA, 3'd4, 1'b1};
        vecs[20] = '{8'hDE, 4'hF, 3'd5, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_syndrome", 32'(out_syndrome), 0);
        chk("rst_out_fixed", 32'(out_fixed), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_err_cnt", 32'(frame_err_cnt), 0);
        chk("rst_total_fixed", 32'(total_fixed), 0);
        rst = 1'b0;

        // out_ready without out_valid must do nothing
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("idle_ready_out_valid", 32'(out_valid), 0);
        chk("idle_ready_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;

        for (int i = 0; i < 21; i++)
            do_word(vecs[i].code, vecs[i].data, vecs[i].syn, vecs[i].fixed, 0, 1'b0);

        do_word(8'hAC, 4'hA, 3'd3, 1'b1, 5, 1'b0);
        do_word(8'hDE, 4'hF, 3'd5, 1'b1, 0, 1'b1);
        do_word(8'hA6, 4'hA, 3'd1, 1'b1, 0, 1'b0);

        // reset while in CALC
        in_valid = 1'b1;
        in_code  = 8'hDE;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rstcalc_out_valid", 32'(out_valid), 0);
        chk("rstcalc_in_ready", 32'(in_ready), 1);
        chk("rstcalc_total_fixed", 32'(total_fixed), 0);
        chk("rstcalc_s_total_fixed", 32'(s_total_fixed), 0);
        chk("rstcalc_frame_err_cnt", 32'(frame_err_cnt), 0);
        chk("rstcalc_out_syndrome", 32'(out_syndrome), 0);
        tot16 = 0; tot2 = 0; acc = 0; wcnt = 0; fe = 0;
        @(posedge clk); @(negedge clk);
        chk("rstcalc_no_output", 32'(out_valid), 0);

        for (int i = 8; i < 16; i++)
            do_word(vecs[i].code, vecs[i].data, vecs[i].syn, vecs[i].fixed, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
